// File: rtl/led_frame_arbiter.sv
// led_frame_arbiter: shares an 8x8 LED matrix driver between two frame
// producers, committing a single pending frame only at scan-frame boundaries.
// Ports:
//   clk, reset (async, active-low)
//   req0_valid/req0_frame/req0_ready : producer 0 handshake (64-bit frame)
//   req1_valid/req1_frame/req1_ready : producer 1 handshake (64-bit frame)
//   frame_out  : displayed frame, bit 8*r+c = row r, column c
//   row_idx    : row being scanned; frame_sync pulses on last cycle of row 7
//   owner      : requester whose frame is displayed
//   pend_full  : pending buffer occupied
// Optional: define LED_FRAME_BLINK_EN to add the blink input, which blanks
//   frame_out on every other scan frame while it is high.
module led_frame_arbiter #(
   parameter int unsigned ROW_DIV     = 1,
   parameter int unsigned HOLD_FRAMES = 2
) (
   input  logic        clk,
   input  logic        reset,
`ifdef LED_FRAME_BLINK_EN
   input  logic        blink,
`endif
   input  logic        req0_valid,
   input  logic [63:0] req0_frame,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [63:0] req1_frame,
   output logic        req1_ready,
   output logic [63:0] frame_out,
   output logic [2:0]  row_idx,
   output logic        frame_sync,
   output logic        owner,
   output logic        pend_full
);

   localparam int unsigned DW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX  = DW'(ROW_DIV - 1);
   localparam logic [3:0]    HOLD_MAX = 4'(HOLD_FRAMES);

   logic [DW-1:0] divider;
   logic [63:0]   frame_reg;
   logic [63:0]   pend_frame;
   logic          pend_src;
   logic          rr;
   logic [3:0]    hold;

   logic holding;
   logic space;
   logic commit;
   logic elig0;
   logic elig1;
   logic gnt0;
   logic gnt1;
   logic accept;

   // ---------------- scan timing ----------------
   assign frame_sync = (row_idx == 3'd7) && (divider == DIV_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         divider <= '0;
         row_idx <= 3'd0;
      end else if (divider == DIV_MAX) begin
         divider <= '0;
         row_idx <= row_idx + 3'd1;
      end else begin
         divider <= divider + DW'(1);
      end
   end

   // ---------------- eligibility / arbitration ----------------
   assign holding = (hold < HOLD_MAX);
   assign commit  = frame_sync && pend_full;
   // The buffer drains into frame_out on a commit edge, so it can be
   // refilled on that same edge.
   assign space   = !pend_full || commit;

   // reset gating keeps ready low while reset is asserted.
   assign elig0 = reset && req0_valid && space && !(holding && owner != 1'b0);
   assign elig1 = reset && req1_valid && space && !(holding && owner != 1'b1);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (elig0 && elig1) begin
         gnt0 = !rr;
         gnt1 = rr;
      end else begin
         gnt0 = elig0;
         gnt1 = elig1;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign accept     = gnt0 || gnt1;

   // ---------------- pending buffer ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_frame <= '0;
         pend_src   <= 1'b0;
         pend_full  <= 1'b0;
         rr         <= 1'b0;
      end else begin
         if (accept) begin
            pend_frame <= gnt1 ? req1_frame : req0_frame;
            pend_src   <= gnt1;
            pend_full  <= 1'b1;
            // pointer moves to the requester that did not win
            rr         <= gnt0;
         end else if (commit) begin
            pend_full  <= 1'b0;
         end
      end
   end

   // ---------------- displayed frame / hold ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_reg <= '0;
         owner     <= 1'b0;
         hold      <= 4'd0;
      end else if (commit) begin
         frame_reg <= pend_frame;
         owner     <= pend_src;
         hold      <= 4'd0;
      end else if (frame_sync && holding) begin
         hold      <= hold + 4'd1;
      end
   end

`ifdef LED_FRAME_BLINK_EN
   logic parity;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity <= 1'b0;
      end else if (frame_sync) begin
         parity <= !parity;
      end
   end

   // The stored frame is untouched; only the view to the driver blanks.
   assign frame_out = (blink && parity) ? 64'd0 : frame_reg;
`else
   assign frame_out = frame_reg;
`endif

endmodule

// File: tb/tb_led_frame_arbiter.sv
// tb_led_frame_arbiter: directed scenario tests for led_frame_arbiter
// with ROW_DIV=1 and HOLD_FRAMES=2.
module tb_led_frame_arbiter;

   logic        clk;
   logic        reset;
   logic        blink;
   logic        req0_valid;
   logic [63:0] req0_frame;
   logic        req0_ready;
   logic        req1_valid;
   logic [63:0] req1_frame;
   logic        req1_ready;
   logic [63:0] frame_out;
   logic [2:0]  row_idx;
   logic        frame_sync;
   logic        owner;
   logic        pend_full;

   int checks;
   int fails;

   localparam logic [63:0] F_A = 64'h00FF_0000_0000_FF00;
   localparam logic [63:0] F_B = 64'h1234_5678_9ABC_DEF0;
   localparam logic [63:0] F_C = 64'hC0C0_C0C0_0303_0303;
   localparam logic [63:0] F_D = 64'hDEAD_BEEF_0BAD_F00D;
   localparam logic [63:0] F_E = 64'h8142_2418_1824_4281;
   localparam logic [63:0] F_F = 64'h5555_AAAA_5555_AAAA;
   localparam logic [63:0] F_G = 64'h0F0F_0F0F_F0F0_F0F0;
   localparam logic [63:0] F_H = 64'h0000_0000_FFFF_0001;
   localparam logic [63:0] F_K = 64'h7E81_A581_A599_817E;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   led_frame_arbiter #(.ROW_DIV(1), .HOLD_FRAMES(2)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef LED_FRAME_BLINK_EN
      .blink      (blink),
`endif
      .req0_valid (req0_valid),
      .req0_frame (req0_frame),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_frame (req1_frame),
      .req1_ready (req1_ready),
      .frame_out  (frame_out),
      .row_idx    (row_idx),
      .frame_sync (frame_sync),
      .owner      (owner),
      .pend_full  (pend_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for_sync();
      int n;
      n = 0;
      while (frame_sync !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (frame_sync !== 1'b1) begin
         checks++;
         fails++;
         $display("FAIL sync_timeout: frame_sync=%b required 1", frame_sync);
      end
   endtask

   task automatic wait_sync(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         wait_for_sync();
         tick();
      end
   endtask

   task automatic wait_row(input logic [2:0] r);
      int n;
      n = 0;
      while (row_idx !== r && n < 40) begin
         tick();
         n++;
      end
      if (row_idx !== r) begin
         checks++;
         fails++;
         $display("FAIL row_timeout: row_idx=%0d required %0d", row_idx, r);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_frame = F_B;
      req1_frame = F_C;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            fails++;
            $display("FAIL rst_ready: got %b required 00", {req0_ready, req1_ready});
         end
      end
      checks++;
      if (frame_out !== 64'd0) begin
         fails++;
         $display("FAIL rst_frame: got %h required 0", frame_out);
      end
      checks++;
      if ({row_idx, frame_sync, owner, pend_full} !== 6'd0) begin
         fails++;
         $display("FAIL rst_state: row=%0d sync=%b own=%b pend=%b required all 0",
                  row_idx, frame_sync, owner, pend_full);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (row_idx !== 3'(i % 8) || frame_sync !== (i % 8 == 7)) begin
            fails++;
            $display("FAIL scan_%0d: row=%0d sync=%b required row=%0d sync=%b",
                     i, row_idx, frame_sync, i % 8, (i % 8 == 7));
         end
         tick();
      end
   endtask

   task automatic test_single_commit();
      wait_row(3'd2);
      req0_valid = 1'b1;
      req0_frame = F_A;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL single_ready: got %b required 10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      checks++;
      if (pend_full !== 1'b1) begin
         fails++;
         $display("FAIL single_pend: got %b required 1", pend_full);
      end
      wait_for_sync();
      checks++;
      if (frame_out !== 64'd0) begin
         fails++;
         $display("FAIL single_early: got %h required 0", frame_out);
      end
      tick();
      checks++;
      if (frame_out !== F_A || owner !== 1'b0 || pend_full !== 1'b0) begin
         fails++;
         $display("FAIL single_commit: frame=%h own=%b pend=%b required %h 0 0",
                  frame_out, owner, pend_full, F_A);
      end
   endtask

   task automatic test_hold();
      int syncs;
      bit got;
      syncs = 0;
      got = 0;
      req1_valid = 1'b1;
      req1_frame = F_B;
      #1;
      for (int i = 0; i < 40 && !got; i++) begin
         if (req1_ready === 1'b1) got = 1;
         else begin
            if (frame_sync === 1'b1) syncs++;
            tick();
         end
      end
      checks++;
      if (got !== 1'b1 || syncs != 2 || row_idx !== 3'd0) begin
         fails++;
         $display("FAIL hold_accept: got=%b syncs=%0d row=%0d required 1 2 0",
                  got, syncs, row_idx);
      end
      tick();
      req1_valid = 1'b0;
      checks++;
      if (pend_full !== 1'b1 || frame_out !== F_A) begin
         fails++;
         $display("FAIL hold_pend: pend=%b frame=%h required 1 %h",
                  pend_full, frame_out, F_A);
      end
      wait_sync(1);
      checks++;
      if (frame_out !== F_B || owner !== 1'b1) begin
         fails++;
         $display("FAIL hold_commit: frame=%h own=%b required %h 1",
                  frame_out, owner, F_B);
      end
   endtask

   task automatic test_contention();
      wait_sync(2);
      req0_valid = 1'b1;
      req0_frame = F_C;
      req1_valid = 1'b1;
      req1_frame = F_D;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL tie1: got %b required 10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_sync(1);
      checks++;
      if (frame_out !== F_C || owner !== 1'b0) begin
         fails++;
         $display("FAIL tie1_commit: frame=%h own=%b required %h 0",
                  frame_out, owner, F_C);
      end
      req1_valid = 1'b1;
      #1;
      checks++;
      if (req1_ready !== 1'b0) begin
         fails++;
         $display("FAIL contend_hold: got %b required 0", req1_ready);
      end
      wait_sync(2);
      checks++;
      if (req1_ready !== 1'b1) begin
         fails++;
         $display("FAIL contend_r1: got %b required 1", req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      wait_sync(1);
      checks++;
      if (frame_out !== F_D || owner !== 1'b1) begin
         fails++;
         $display("FAIL contend_commit: frame=%h own=%b required %h 1",
                  frame_out, owner, F_D);
      end
      wait_sync(2);
      req0_valid = 1'b1;
      req0_frame = F_E;
      req1_valid = 1'b1;
      req1_frame = F_F;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL tie2: got %b required 10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_sync(1);
      checks++;
      if (frame_out !== F_E || owner !== 1'b0) begin
         fails++;
         $display("FAIL tie2_commit: frame=%h own=%b required %h 0",
                  frame_out, owner, F_E);
      end
   endtask

   task automatic test_same_edge();
      req0_valid = 1'b1;
      req0_frame = F_G;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         fails++;
         $display("FAIL owner_resubmit: got %b required 1", req0_ready);
      end
      tick();
      req0_valid = 1'b0;
      wait_for_sync();
      req0_valid = 1'b1;
      req0_frame = F_H;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || pend_full !== 1'b1) begin
         fails++;
         $display("FAIL refill_ready: ready=%b pend=%b required 1 1",
                  req0_ready, pend_full);
      end
      tick();
      req0_valid = 1'b0;
      checks++;
      if (frame_out !== F_G || pend_full !== 1'b1) begin
         fails++;
         $display("FAIL refill_drain: frame=%h pend=%b required %h 1",
                  frame_out, pend_full, F_G);
      end
      wait_sync(1);
      checks++;
      if (frame_out !== F_H || pend_full !== 1'b0) begin
         fails++;
         $display("FAIL refill_commit: frame=%h pend=%b required %h 0",
                  frame_out, pend_full, F_H);
      end
   endtask

   task automatic test_mid_reset();
      req0_valid = 1'b1;
      req0_frame = F_K;
      tick();
      checks++;
      if (pend_full !== 1'b1) begin
         fails++;
         $display("FAIL mid_pend: got %b required 1", pend_full);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || pend_full !== 1'b0 || frame_out !== 64'd0 ||
          row_idx !== 3'd0 || owner !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: rdy=%b pend=%b frame=%h row=%0d own=%b required 0 0 0 0 0",
                  req0_ready, pend_full, frame_out, row_idx, owner);
      end
      req0_valid = 1'b0;
      tick();
      reset = 1'b1;
      wait_sync(1);
      checks++;
      if (frame_out !== 64'd0 || pend_full !== 1'b0) begin
         fails++;
         $display("FAIL mid_abandon: frame=%h pend=%b required 0 0",
                  frame_out, pend_full);
      end
   endtask

`ifdef LED_FRAME_BLINK_EN
   task automatic test_blink();
      bit par;
      logic [63:0] exp;
      par = 1'b1;
      req0_valid = 1'b1;
      req0_frame = ONES;
      tick();
      req0_valid = 1'b0;
      blink = 1'b1;
      wait_sync(1);
      par = ~par;
      for (int i = 0; i < 4; i++) begin
         exp = par ? 64'd0 : ONES;
         checks++;
         if (frame_out !== exp) begin
            fails++;
            $display("FAIL blink_%0d: got %h required %h", i, frame_out, exp);
         end
         wait_sync(1);
         par = ~par;
      end
      blink = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (frame_out !== ONES) begin
            fails++;
            $display("FAIL steady_%0d: got %h required %h", i, frame_out, ONES);
         end
         wait_sync(1);
      end
   endtask
`endif

   initial begin
      checks = 0;
      fails = 0;
      blink = 1'b0;
      reset = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_frame = 64'd0;
      req1_frame = 64'd0;
      test_reset();
      test_single_commit();
      test_hold();
      test_contention();
      test_same_edge();
      test_mid_reset();
`ifdef LED_FRAME_BLINK_EN
      test_blink();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
